// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle MIPS-subset control FSM (clk, rst_n, instruction, mem_ready, zero in; datapath controls, ALUOp, state_o, trap, retired out)
module multicycle_control #(
  parameter int ALUOP_W  = 6,
  parameter int CNT_W    = 16,
  parameter int WAIT_MAX = 15,
  parameter int EN_BRJ   = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        instruction,
  input  logic               mem_ready,
  input  logic               zero,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               IRWrite,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               MemToReg,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSource,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [3:0]         state_o,
  output logic               trap,
  output logic [CNT_W-1:0]   retired
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, ADDIEX, ADDIWB, BRANCH, JUMP, HALT
  } state_t;
  localparam int WW = WAIT_MAX > 1 ? $clog2(WAIT_MAX + 1) : 1;
  localparam logic [5:0] ADD = 6'h20;
  localparam logic [5:0] SUB = 6'h22;
  state_t state, nxt;
  logic [WW-1:0] wcnt;
  logic [5:0] op, fn;
  logic waiting, timeout, rtype_ok, brj_ok, done, unused_zero;
  assign op = instruction[31:26];
  assign fn = instruction[5:0];
  assign unused_zero = zero;
  assign waiting = (state == FETCH || state == MEMRD || state == MEMWR) && !mem_ready;
  // the access that would make the wait count reach WAIT_MAX traps instead
  assign timeout = waiting && wcnt == WW'(WAIT_MAX - 1);
  assign rtype_ok = fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27};
  assign brj_ok = EN_BRJ != 0;
  assign state_o = state;
  always_comb begin
    nxt = state;
    done = 1'b0;
    case (state)
      FETCH:  nxt = timeout ? HALT : mem_ready ? DECODE : FETCH;
      DECODE: nxt = op == 6'h00 ? (rtype_ok ? EXEC : HALT) :
                    op == 6'h08 ? ADDIEX :
                    (op == 6'h23 || op == 6'h2b) ? MEMADR :
                    (op == 6'h04 && brj_ok) ? BRANCH :
                    (op == 6'h02 && brj_ok) ? JUMP : HALT;
      MEMADR: nxt = op == 6'h2b ? MEMWR : MEMRD;
      MEMRD:  nxt = timeout ? HALT : mem_ready ? MEMWB : MEMRD;
      MEMWR: begin
        nxt = timeout ? HALT : mem_ready ? FETCH : MEMWR;
        done = mem_ready;
      end
      EXEC:   nxt = ALUWB;
      ADDIEX: nxt = ADDIWB;
      MEMWB, ALUWB, ADDIWB, BRANCH, JUMP: begin
        nxt = FETCH;
        done = 1'b1;
      end
      default: nxt = HALT;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= FETCH;
      trap    <= 1'b0;
      retired <= '0;
      wcnt    <= '0;
    end else begin
      state   <= nxt;
      trap    <= trap | (nxt == HALT);
      retired <= retired + CNT_W'(done);
      wcnt    <= waiting ? wcnt + 1'b1 : '0;
    end
  end
  always_comb begin
    {PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite, MemToReg, RegDst, RegWrite, ALUSrcA} = '0;
    ALUSrcB  = 2'b00;
    PCSource = 2'b00;
    ALUOp    = '0;
    case (state)
      FETCH: begin
        MemRead = 1'b1;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        ALUSrcB = 2'b01;
        ALUOp   = ALUOP_W'(ADD);
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        ALUOp   = ALUOP_W'(ADD);
      end
      MEMADR, ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = ALUOP_W'(ADD);
      end
      MEMRD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      MEMWB: begin
        MemToReg = 1'b1;
        RegWrite = 1'b1;
      end
      EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_W'(fn);
      end
      ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      ADDIWB: RegWrite = 1'b1;
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALUOP_W'(SUB);
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      default: ;
    endcase
    // in reset only the fetch read stays requested
    if (!rst_n) begin
      {PCWrite, PCWriteCond, IorD, IRWrite, MemWrite, MemToReg, RegDst, RegWrite, ALUSrcA} = '0;
      MemRead  = 1'b1;
      ALUSrcB  = 2'b00;
      PCSource = 2'b00;
      ALUOp    = '0;
    end
  end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: randomized scoreboard bench for multicycle_control
module tb_multicycle_control;
  localparam int WAIT_MAX = 15;
  logic clk = 1'b0, rst_n = 1'b0, mem_ready = 1'b1, zero = 1'b0;
  logic [31:0] instruction = '0;
  logic pcw, pcwc, iord, irw, mrd, mwr, m2r, rdst, rwr, asa, trap;
  logic [1:0] asb, psrc;
  logic [5:0] aluop;
  logic [3:0] st;
  logic [15:0] retired;
  logic b_pcw, b_pcwc, b_iord, b_irw, b_mrd, b_mwr, b_m2r, b_rdst, b_rwr, b_asa, b_trap;
  logic [1:0] b_asb, b_psrc, b_retired;
  logic [5:0] b_aluop;
  logic [3:0] b_st;
  logic [19:0] ctrl;
  assign ctrl = {pcw, pcwc, iord, irw, mrd, mwr, m2r, rdst, rwr, asa, asb, psrc, aluop};

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .instruction(instruction), .mem_ready(mem_ready), .zero(zero),
    .PCWrite(pcw), .PCWriteCond(pcwc), .IorD(iord), .IRWrite(irw), .MemRead(mrd), .MemWrite(mwr),
    .MemToReg(m2r), .RegDst(rdst), .RegWrite(rwr), .ALUSrcA(asa), .ALUSrcB(asb), .PCSource(psrc),
    .ALUOp(aluop), .state_o(st), .trap(trap), .retired(retired)
  );

  multicycle_control #(.CNT_W(2), .EN_BRJ(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .instruction(instruction), .mem_ready(mem_ready), .zero(zero),
    .PCWrite(b_pcw), .PCWriteCond(b_pcwc), .IorD(b_iord), .IRWrite(b_irw), .MemRead(b_mrd), .MemWrite(b_mwr),
    .MemToReg(b_m2r), .RegDst(b_rdst), .RegWrite(b_rwr), .ALUSrcA(b_asa), .ALUSrcB(b_asb), .PCSource(b_psrc),
    .ALUOp(b_aluop), .state_o(b_st), .trap(b_trap), .retired(b_retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          st;
    logic [19:0] ctrl;
    bit          trp;
    logic [15:0] ret;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int checks = 0, passes = 0;
  logic [15:0] ret_cnt = '0;
  bit exp_trap = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
  endtask

  // expected controls for each state, straight from the datapath control table
  function automatic logic [19:0] exp_ctrl(input int s, input bit rdy, input logic [5:0] fn);
    logic pw, pwc, id, ir, mr, mw, mtr, rd, rw, sa;
    logic [1:0] sb, ps;
    logic [5:0] op;
    {pw, pwc, id, ir, mr, mw, mtr, rd, rw, sa} = '0;
    sb = 2'b00; ps = 2'b00; op = 6'h00;
    case (s)
      0:  begin pw = rdy; ir = rdy; mr = 1; sb = 2'b01; op = 6'h20; end
      1:  begin sb = 2'b11; op = 6'h20; end
      2:  begin sa = 1; sb = 2'b10; op = 6'h20; end
      3:  begin id = 1; mr = 1; end
      4:  begin mtr = 1; rw = 1; end
      5:  begin id = 1; mw = 1; end
      6:  begin sa = 1; op = fn; end
      7:  begin rd = 1; rw = 1; end
      8:  begin sa = 1; sb = 2'b10; op = 6'h20; end
      9:  rw = 1;
      10: begin sa = 1; op = 6'h22; pwc = 1; ps = 2'b01; end
      11: begin pw = 1; ps = 2'b10; end
      default: ;
    endcase
    return {pw, pwc, id, ir, mr, mw, mtr, rd, rw, sa, sb, ps, op};
  endfunction

  function automatic bit rb();
    return 1'($urandom);
  endfunction

  function automatic int rw();
    return ($urandom_range(0, 9) == 0) ? WAIT_MAX - 1 : int'($urandom_range(0, 3));
  endfunction

  function automatic bit legal_fn(input logic [5:0] fn);
    return fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27};
  endfunction

  // instruction classes: 0 R, 1 ADDI, 2 LW, 3 SW, 4 BEQ, 5 J, 6 bad opcode, 7 bad funct
  function automatic logic [31:0] mk(input int cls);
    logic [31:0] i;
    logic [5:0] op, fn;
    logic [5:0] lf [6];
    lf = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27};
    i = $urandom;
    fn = i[5:0];
    op = 6'h00;
    case (cls)
      0: fn = lf[$urandom_range(0, 5)];
      1: op = 6'h08;
      2: op = 6'h23;
      3: op = 6'h2b;
      4: op = 6'h04;
      5: op = 6'h02;
      6: do op = 6'($urandom); while (op inside {6'h00, 6'h08, 6'h23, 6'h2b, 6'h04, 6'h02});
      default: do fn = 6'($urandom); while (legal_fn(fn));
    endcase
    i[31:26] = op;
    i[5:0] = fn;
    return i;
  endfunction

  // one clock cycle: drive inputs, queue what the DUT must show during it
  task automatic cyc(input int s, input bit rdy);
    exp_t x;
    mem_ready = rdy;
    x.st = s;
    x.ctrl = exp_ctrl(s, rdy, instruction[5:0]);
    x.trp = exp_trap;
    x.ret = ret_cnt;
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    mem_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rst_state", 32'(st), 0);
    chk("rst_ctrl", 32'(ctrl), 32'h0000_8000);
    chk("rst_trap", 32'(trap), 0);
    chk("rst_retired", 32'(retired), 0);
    chk("rst_trap2", 32'(b_trap), 0);
    ret_cnt = '0;
    exp_trap = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic run(input int cls, input logic [31:0] ins, input int wf, input int wm, input bit z);
    instruction = ins;
    zero = z;
    repeat (wf) cyc(0, 0);
    cyc(0, 1);
    cyc(1, rb());
    case (cls)
      0: begin cyc(6, rb()); cyc(7, rb()); ret_cnt++; end
      1: begin cyc(8, rb()); cyc(9, rb()); ret_cnt++; end
      2: begin cyc(2, rb()); repeat (wm) cyc(3, 0); cyc(3, 1); cyc(4, rb()); ret_cnt++; end
      3: begin cyc(2, rb()); repeat (wm) cyc(5, 0); cyc(5, 1); ret_cnt++; end
      4: begin cyc(10, rb()); ret_cnt++; end
      5: begin cyc(11, rb()); ret_cnt++; end
      default: begin
        exp_trap = 1'b1;
        repeat (2) cyc(12, rb());
        do_reset();
      end
    endcase
  endtask

  // where: 0 fetch, 1 LW read, 2 SW write
  task automatic tmo(input int where);
    instruction = (where == 2) ? mk(3) : mk(2);
    zero = 1'b0;
    if (where == 0) repeat (WAIT_MAX) cyc(0, 0);
    else begin
      cyc(0, 1);
      cyc(1, rb());
      cyc(2, rb());
      repeat (WAIT_MAX) cyc(where == 1 ? 3 : 5, 0);
    end
    exp_trap = 1'b1;
    repeat (2) cyc(12, rb());
    do_reset();
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("state", 32'(st), e.st);
      chk("ctrl", 32'(ctrl), 32'(e.ctrl));
      chk("trap", 32'(trap), 32'(e.trp));
      chk("retired", 32'(retired), 32'(e.ret));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int c;
    @(posedge clk);
    #1;
    do_reset();
    run(0, 32'h0109_5020, 0, 0, 0);
    run(2, 32'h8c00_0004, 0, 3, 0);
    run(4, 32'h1000_0003, 0, 0, 1);
    run(4, 32'h1000_0003, 0, 0, 0);
    run(3, 32'hac00_0008, 0, 0, 0);
    run(5, 32'h0800_0010, 0, 0, 0);
    run(1, 32'h2000_0005, WAIT_MAX - 1, 0, 0);
    run(3, 32'hac00_0008, 0, WAIT_MAX - 1, 0);
    run(2, 32'h8c00_0004, 0, WAIT_MAX - 1, 0);
    run(6, 32'hfc00_0000, 0, 0, 0);
    run(7, 32'h0000_0000, 0, 0, 0);
    tmo(0);
    tmo(1);
    tmo(2);
    repeat (5) run(1, mk(1), rw(), 0, rb());
    chk("cnt2_wrap", 32'(b_retired), 1);
    run(5, mk(5), 0, 0, 0);
    chk("nobrj_trap", 32'(b_trap), 1);
    chk("nobrj_halt", 32'(b_st), 12);
    repeat (150) begin
      c = $urandom_range(0, 19);
      c = (c < 8) ? c : c % 6;
      run(c, mk(c), rw(), rw(), rb());
    end
    @(negedge clk);
    chk("drain", q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
